// File: rtl/axil_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_pkg;

  // Controller states: one command in flight at a time.
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  // AXI response codes.
  typedef logic [1:0] resp_t;
  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;
  localparam resp_t DECERR = 2'b11;

  // Default per-phase wait limit and the width of the phase counter.
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int PHASE_CNT_WIDTH        = 16;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a slave.
interface Bus2Master_intf
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  resp_t                   bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  resp_t                   rresp;
  logic                    rvalid;
  logic                    rready;

  modport master_ports (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave_ports (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axil_cmd_master_timer.sv
// Phase timer: counts cycles spent in the current bus phase and flags
// when the wait limit has been reached. Saturates so expiry stays asserted.
module axil_phase_timer
  import axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);

  localparam logic [PHASE_CNT_WIDTH-1:0] LIMIT = PHASE_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [PHASE_CNT_WIDTH-1:0] count;

  // Clear on every state entry, otherwise count up and hold at the maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count >= LIMIT);

endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite command master: accepts one read or write command, runs it on
// the bus with a per-phase timeout, and returns a single response.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  Bus2Master_intf.master_ports    MAXI
);

  state_t state, state_next;

  logic ready_q;
  logic aw_done, aw_done_next;
  logic w_done, w_done_next;
  logic awvalid_q, awvalid_next;
  logic wvalid_q, wvalid_next;
  logic arvalid_q, arvalid_next;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_next;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_next;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_next;
  resp_t                   resp_q, resp_next;
  logic                    timeout_q, timeout_next;

  logic aw_hs, w_hs, ar_hs, expire, restart;

  assign aw_hs   = awvalid_q && MAXI.awready;
  assign w_hs    = wvalid_q && MAXI.wready;
  assign ar_hs   = arvalid_q && MAXI.arready;
  assign restart = (state_next != state);

  axil_phase_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .expire (expire)
  );

  // Next-state and next-register logic; a handshake always beats expiry.
  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    awvalid_next = awvalid_q;
    wvalid_next  = wvalid_q;
    arvalid_next = arvalid_q;
    addr_next    = addr_q;
    wdata_next   = wdata_q;
    wstrb_next   = wstrb_q;
    rdata_next   = rdata_q;
    resp_next    = resp_q;
    timeout_next = timeout_q;

    case (state)
      IDLE: begin
        if (req_valid && ready_q) begin
          addr_next    = req_addr;
          wdata_next   = req_wdata;
          wstrb_next   = req_wstrb;
          rdata_next   = '0;
          resp_next    = OKAY;
          timeout_next = 1'b0;
          if (req_write) begin
            state_next   = WR_REQ;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
          end else begin
            state_next   = RD_REQ;
            arvalid_next = 1'b1;
          end
        end
      end

      WR_REQ: begin
        if (aw_done && w_done) begin
          state_next = WR_RESP;
        end else if (!aw_hs && !w_hs && expire) begin
          state_next   = RSP;
          awvalid_next = 1'b0;
          wvalid_next  = 1'b0;
          timeout_next = 1'b1;
          resp_next    = SLVERR;
        end else begin
          if (aw_hs) begin
            awvalid_next = 1'b0;
            aw_done_next = 1'b1;
          end
          if (w_hs) begin
            wvalid_next = 1'b0;
            w_done_next = 1'b1;
          end
        end
      end

      WR_RESP: begin
        if (MAXI.bvalid) begin
          state_next = RSP;
          resp_next  = MAXI.bresp;
        end else if (expire) begin
          state_next   = RSP;
          timeout_next = 1'b1;
          resp_next    = SLVERR;
        end
      end

      RD_REQ: begin
        if (ar_hs) begin
          state_next   = RD_DATA;
          arvalid_next = 1'b0;
        end else if (expire) begin
          state_next   = RSP;
          arvalid_next = 1'b0;
          timeout_next = 1'b1;
          resp_next    = SLVERR;
        end
      end

      RD_DATA: begin
        if (MAXI.rvalid) begin
          state_next = RSP;
          rdata_next = MAXI.rdata;
          resp_next  = MAXI.rresp;
        end else if (expire) begin
          state_next   = RSP;
          timeout_next = 1'b1;
          resp_next    = SLVERR;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command, bus-drive and response registers; all cleared while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      timeout_q <= 1'b0;
    end else begin
      ready_q   <= (state_next == IDLE);
      aw_done   <= aw_done_next;
      w_done    <= w_done_next;
      awvalid_q <= awvalid_next;
      wvalid_q  <= wvalid_next;
      arvalid_q <= arvalid_next;
      addr_q    <= addr_next;
      wdata_q   <= wdata_next;
      wstrb_q   <= wstrb_next;
      rdata_q   <= rdata_next;
      resp_q    <= resp_next;
      timeout_q <= timeout_next;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = (state == RSP);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;

  assign MAXI.awaddr  = addr_q;
  assign MAXI.awprot  = 3'b000;
  assign MAXI.awvalid = awvalid_q;
  assign MAXI.wdata   = wdata_q;
  assign MAXI.wstrb   = wstrb_q;
  assign MAXI.wvalid  = wvalid_q;
  assign MAXI.bready  = (state == WR_RESP);
  assign MAXI.araddr  = addr_q;
  assign MAXI.arprot  = 3'b000;
  assign MAXI.arvalid = arvalid_q;
  assign MAXI.rready  = (state == RD_DATA);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a small AXI4-Lite slave model.
module tb_axil_cmd_master;
  import axil_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  Bus2Master_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) maxi_bus ();

  axil_cmd_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .MAXI       (maxi_bus)
  );

  // Slave model: zero-wait by default, ready/response gating knobs below.
  logic          aw_en = 1'b1;
  logic          w_en  = 1'b1;
  logic          ar_en = 1'b1;
  logic          b_en  = 1'b1;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_lat;
  logic [DW-1:0] w_lat;
  logic [3:0]    s_lat;
  logic          aw_now, w_now, ar_now;
  logic [AW-1:0] a_cur;
  logic [DW-1:0] d_cur;
  logic [3:0]    s_cur;
  int            b_count;
  logic [31:0]   mem [0:15];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  end

  assign maxi_bus.awready = aw_en;
  assign maxi_bus.wready  = w_en;
  assign maxi_bus.arready = ar_en;
  assign aw_now = maxi_bus.awvalid && maxi_bus.awready;
  assign w_now  = maxi_bus.wvalid && maxi_bus.wready;
  assign ar_now = maxi_bus.arvalid && maxi_bus.arready;
  assign a_cur  = aw_now ? maxi_bus.awaddr : aw_lat;
  assign d_cur  = w_now ? maxi_bus.wdata : w_lat;
  assign s_cur  = w_now ? maxi_bus.wstrb : s_lat;

  // Slave write/read channel behaviour with registered responses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got          <= 1'b0;
      w_got           <= 1'b0;
      aw_lat          <= '0;
      w_lat           <= '0;
      s_lat           <= '0;
      maxi_bus.bvalid <= 1'b0;
      maxi_bus.bresp  <= OKAY;
      maxi_bus.rvalid <= 1'b0;
      maxi_bus.rdata  <= '0;
      maxi_bus.rresp  <= OKAY;
      b_count         <= 0;
    end else begin
      if (maxi_bus.bvalid && maxi_bus.bready) begin
        maxi_bus.bvalid <= 1'b0;
        b_count         <= b_count + 1;
      end
      if ((aw_got || aw_now) && (w_got || w_now) && !maxi_bus.bvalid && b_en) begin
        maxi_bus.bvalid <= 1'b1;
        aw_got          <= 1'b0;
        w_got           <= 1'b0;
        if (a_cur >= 32'hFFFF_0000) begin
          maxi_bus.bresp <= SLVERR;
        end else begin
          maxi_bus.bresp <= OKAY;
          for (int b = 0; b < 4; b++) begin
            if (s_cur[b]) mem[a_cur[5:2]][8*b +: 8] <= d_cur[8*b +: 8];
          end
        end
      end else begin
        if (aw_now) begin
          aw_got <= 1'b1;
          aw_lat <= maxi_bus.awaddr;
        end
        if (w_now) begin
          w_got <= 1'b1;
          w_lat <= maxi_bus.wdata;
          s_lat <= maxi_bus.wstrb;
        end
      end
      if (maxi_bus.rvalid && maxi_bus.rready) begin
        maxi_bus.rvalid <= 1'b0;
      end else if (ar_now && !maxi_bus.rvalid) begin
        maxi_bus.rvalid <= 1'b1;
        if (maxi_bus.araddr >= 32'hFFFF_0000) begin
          maxi_bus.rdata <= '0;
          maxi_bus.rresp <= SLVERR;
        end else begin
          maxi_bus.rdata <= mem[maxi_bus.araddr[5:2]];
          maxi_bus.rresp <= OKAY;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command and let the DUT accept it on the next edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("req_ready_before_cmd", 64'(req_ready), 64'(1));
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    req_wstrb = strb;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Called in the cycle after accept; lat is the cycle index of rsp_valid.
  task automatic waitResponse(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      tick();
      lat++;
    end
    checkOutput("rsp_valid_seen", 64'(rsp_valid), 64'(1));
  endtask

  task automatic finishResponse();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_after_take", 64'(rsp_valid), 64'(0));
    checkOutput("req_ready_after_take", 64'(req_ready), 64'(1));
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] exp_resp);
    int lat;
    applyStimulus(1'b1, addr, data, strb);
    waitResponse(lat);
    checkOutput("write_latency", 64'(lat), 64'(4));
    checkOutput("write_resp", 64'(rsp_resp), 64'(exp_resp));
    checkOutput("write_timeout", 64'(rsp_timeout), 64'(0));
    checkOutput("write_rdata_zero", 64'(rsp_rdata), 64'(0));
    finishResponse();
  endtask

  task automatic doRead(input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    int lat;
    applyStimulus(1'b0, addr, 32'h0, 4'h0);
    waitResponse(lat);
    checkOutput("read_latency", 64'(lat), 64'(3));
    checkOutput("read_rdata", 64'(rsp_rdata), 64'(exp_data));
    checkOutput("read_resp", 64'(rsp_resp), 64'(exp_resp));
    checkOutput("read_timeout", 64'(rsp_timeout), 64'(0));
    finishResponse();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    int lat;

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("rst_awvalid", 64'(maxi_bus.awvalid), 64'(0));
    checkOutput("rst_arvalid", 64'(maxi_bus.arvalid), 64'(0));
    checkOutput("rst_bready", 64'(maxi_bus.bready), 64'(0));
    checkOutput("rst_rready", 64'(maxi_bus.rready), 64'(0));
    checkOutput("rst_awaddr", 64'(maxi_bus.awaddr), 64'(0));
    checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    rst = 1'b0;
    checkOutput("req_ready_before_first_edge", 64'(req_ready), 64'(0));
    tick();
    checkOutput("req_ready_after_first_edge", 64'(req_ready), 64'(1));

    // Basic write then read-back.
    doWrite(32'h0, 32'hDEAD_BEEF, 4'hF, OKAY);
    checkOutput("b_count_first_write", 64'(b_count), 64'(1));
    doRead(32'h0, 32'hDEAD_BEEF, OKAY);

    // AW accepted three cycles before W.
    w_en = 1'b0;
    applyStimulus(1'b1, 32'h8, 32'h1234_5678, 4'hF);
    checkOutput("split_c1_awvalid", 64'(maxi_bus.awvalid), 64'(1));
    checkOutput("split_c1_wvalid", 64'(maxi_bus.wvalid), 64'(1));
    tick();
    checkOutput("split_c2_awvalid", 64'(maxi_bus.awvalid), 64'(0));
    checkOutput("split_c2_wvalid", 64'(maxi_bus.wvalid), 64'(1));
    tick();
    checkOutput("split_c3_wvalid", 64'(maxi_bus.wvalid), 64'(1));
    checkOutput("split_c3_wdata", 64'(maxi_bus.wdata), 64'(32'h1234_5678));
    tick();
    checkOutput("split_c4_wvalid", 64'(maxi_bus.wvalid), 64'(1));
    checkOutput("split_c4_awaddr", 64'(maxi_bus.awaddr), 64'(32'h8));
    w_en = 1'b1;
    tick();
    checkOutput("split_c5_wvalid", 64'(maxi_bus.wvalid), 64'(0));
    waitResponse(lat);
    checkOutput("split_resp", 64'(rsp_resp), 64'(OKAY));
    checkOutput("split_timeout", 64'(rsp_timeout), 64'(0));
    finishResponse();
    checkOutput("split_b_count", 64'(b_count), 64'(2));
    repeat (3) tick();
    checkOutput("split_b_count_later", 64'(b_count), 64'(2));
    checkOutput("split_bvalid_idle", 64'(maxi_bus.bvalid), 64'(0));
    doRead(32'h8, 32'h1234_5678, OKAY);

    // Partial strobe write.
    doWrite(32'h8, 32'hAAAA_5555, 4'b0011, OKAY);
    doRead(32'h8, 32'h1234_5555, OKAY);

    // Slave error on a read.
    doRead(32'hFFFF_FFFC, 32'h0, SLVERR);

    // Read address phase never accepted: timeout.
    ar_en = 1'b0;
    applyStimulus(1'b0, 32'h4, 32'h0, 4'h0);
    checkOutput("to_arvalid_rise", 64'(maxi_bus.arvalid), 64'(1));
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("to_cycles", 64'(n), 64'(8));
    checkOutput("to_flag", 64'(rsp_timeout), 64'(1));
    checkOutput("to_resp", 64'(rsp_resp), 64'(SLVERR));
    checkOutput("to_arvalid_low", 64'(maxi_bus.arvalid), 64'(0));
    checkOutput("to_rready_low", 64'(maxi_bus.rready), 64'(0));
    checkOutput("to_rdata", 64'(rsp_rdata), 64'(0));

    // Response back-pressure for five cycles.
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      checkOutput("hold_req_ready", 64'(req_ready), 64'(0));
      checkOutput("hold_resp", 64'(rsp_resp), 64'(SLVERR));
      checkOutput("hold_timeout", 64'(rsp_timeout), 64'(1));
      tick();
    end
    finishResponse();
    ar_en = 1'b1;

    // Reset pulse while waiting for B.
    b_en = 1'b0;
    applyStimulus(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
    tick();
    tick();
    checkOutput("pre_rst_bready", 64'(maxi_bus.bready), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_bready", 64'(maxi_bus.bready), 64'(0));
    checkOutput("midrst_awvalid", 64'(maxi_bus.awvalid), 64'(0));
    checkOutput("midrst_wvalid", 64'(maxi_bus.wvalid), 64'(0));
    checkOutput("midrst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("midrst_rsp_timeout", 64'(rsp_timeout), 64'(0));
    checkOutput("midrst_rsp_resp", 64'(rsp_resp), 64'(0));
    checkOutput("midrst_awaddr", 64'(maxi_bus.awaddr), 64'(0));
    checkOutput("midrst_wdata", 64'(maxi_bus.wdata), 64'(0));
    checkOutput("midrst_wstrb", 64'(maxi_bus.wstrb), 64'(0));
    tick();
    rst  = 1'b0;
    b_en = 1'b1;
    tick();
    doWrite(32'h10, 32'hCAFE_F00D, 4'hF, OKAY);
    doRead(32'h10, 32'hCAFE_F00D, OKAY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
